// File: rtl/uart_tx_fifo.sv
// Byte FIFO with an issue sequencer feeding an 8N2 UART transmitter.
// Bytes are popped one at a time and handed over with a single-cycle start pulse.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    state_t            state;
    state_t            stateNext;
    logic              waitCnt;
    logic              waitCntNext;
    logic              txStartNext;
    logic              pop;
    logic              wrAccept;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    // A full FIFO still takes a write when the sequencer pops in the same cycle.
    assign wrAccept = wr_en && (!full || pop);

    always_comb begin
        stateNext   = state;
        waitCntNext = 1'b0;
        txStartNext = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop         = 1'b1;
                    txStartNext = 1'b1;
                    stateNext   = ISSUE;
                end
            end
            ISSUE: begin
                stateNext = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Give the transmitter two cycles to raise busy; otherwise treat the byte as sent.
                if (tx_busy) begin
                    stateNext = WAIT_DONE;
                end else if (waitCnt) begin
                    stateNext = IDLE;
                end else begin
                    waitCntNext = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            waitCnt  <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            tx_start <= txStartNext;
            if (pop) begin
                tx_data <= mem[rdPtr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            case ({wrAccept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped write wins over a simultaneous clear.
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural transmitter plus a byte-queue reference model.
// Directed scenarios followed by a randomized write/clear phase.
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int AW       = $clog2(DEPTH);
    localparam int BUSY_LEN = 22;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy)
    );

    // Transmitter: samples start, raises busy one cycle later, holds it BUSY_LEN cycles.
    logic ignoreStart = 1'b0;
    logic txPend      = 1'b0;
    int   txCnt       = 0;

    always @(posedge clk) begin
        if (txPend) begin
            txPend <= 1'b0;
            txCnt  <= BUSY_LEN;
        end else if (txCnt != 0) begin
            txCnt <= txCnt - 1;
        end else if (tx_start && !ignoreStart) begin
            txPend <= 1'b1;
        end
    end
    assign tx_busy = (txCnt != 0);

    int         checks = 0;
    int         errors = 0;
    logic [7:0] refQ[$];
    logic       expOvf       = 1'b0;
    logic [7:0] lastTx       = 8'h00;
    int         cyc          = 0;
    int         lastStartCyc = -1;
    int         startCount   = 0;
    int         gapMode      = 0;
    logic       prevStart    = 1'b0;
    int         base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and update the reference model with what the edge did.
    task automatic cycle();
        logic       rstE;
        logic       wE;
        logic       clrE;
        logic       busyE;
        logic [7:0] dE;
        int         sizeE;
        logic       dropped;
        rstE  = resetn;
        wE    = wr_en;
        clrE  = clr_overflow;
        dE    = wr_data;
        busyE = tx_busy;
        sizeE = refQ.size();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!rstE) begin
            refQ.delete();
            expOvf       = 1'b0;
            lastTx       = 8'h00;
            lastStartCyc = -1;
            chk("rst_tx_start", 32'(tx_start), 0);
        end else begin
            dropped = wE && (sizeE == DEPTH) && !tx_start;
            if (tx_start) begin
                startCount++;
                chk("start_width", 32'(prevStart), 0);
                chk("start_while_busy", 32'(busyE), 0);
                chk("start_nonempty", 32'(sizeE != 0), 1);
                if (sizeE != 0) lastTx = refQ.pop_front();
                if (lastStartCyc >= 0 && gapMode == 1)
                    chk("start_gap_gt_busy", 32'((cyc - lastStartCyc) > BUSY_LEN), 1);
                if (lastStartCyc >= 0 && gapMode == 2)
                    chk("stuck_gap", 32'(cyc - lastStartCyc), 4);
                lastStartCyc = cyc;
            end
            if (wE && !dropped) refQ.push_back(dE);
            if (dropped) expOvf = 1'b1;
            else if (clrE) expOvf = 1'b0;
        end
        chk("count", 32'(count), 32'(refQ.size()));
        chk("full", 32'(full), 32'(refQ.size() == DEPTH));
        chk("empty", 32'(empty), 32'(refQ.size() == 0));
        chk("overflow", 32'(overflow), 32'(expOvf));
        chk("tx_data", 32'(tx_data), 32'(lastTx));
        prevStart = tx_start;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        int quiet;
        n     = 0;
        quiet = 0;
        while (quiet < 6 && n < limit) begin
            cycle();
            n++;
            if (refQ.size() == 0 && !tx_busy && !txPend) quiet++;
            else quiet = 0;
        end
        chk("drain_done", 32'(quiet >= 6), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        resetn       = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        resetn = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        cycle();

        // Single byte: start one cycle after the write edge, one-cycle pulse.
        gapMode = 1;
        base    = startCount;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        cycle();
        wr_en = 1'b0;
        chk("a5_no_fallthrough", 32'(tx_start), 0);
        chk("a5_count1", 32'(count), 1);
        cycle();
        chk("a5_start", 32'(tx_start), 1);
        chk("a5_data", 32'(tx_data), 32'h A5);
        chk("a5_count0", 32'(count), 0);
        cycle();
        chk("a5_pulse_end", 32'(tx_start), 0);
        drain(200);
        chk("a5_one_start", 32'(startCount - base), 1);
        chk("a5_empty", 32'(empty), 1);

        // Burst of 16; the first byte is popped while the burst is still arriving.
        base = startCount;
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("burst_count", 32'(count), 15);
        chk("burst_not_full", 32'(full), 0);
        drain(1500);
        chk("burst_starts", 32'(startCount - base), 16);
        chk("burst_last", 32'(tx_data), 32'h0F);

        // Overflow: fill behind a busy transmitter, then drop and clear.
        wr(8'h11);
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
        chk("ovf_count16", 32'(count), 16);
        chk("ovf_full", 32'(full), 1);
        wr(8'hFF);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count_kept", 32'(count), 16);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        clr_overflow = 1'b1;
        wr(8'hEE);
        clr_overflow = 1'b0;
        chk("ovf_set_beats_clr", 32'(overflow), 1);

        // Keep writing into the full FIFO until the pop edge; only that write is accepted.
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        for (int k = 0; k < 100 && !tx_start; k++) cycle();
        wr_en = 1'b0;
        chk("fullpop_started", 32'(tx_start), 1);
        chk("fullpop_count16", 32'(count), 16);
        chk("fullpop_full", 32'(full), 1);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        drain(2000);
        chk("fullpop_last", 32'(tx_data), 32'h C3);

        // Transmitter that never goes busy: lost-start recovery paces issues 4 cycles apart.
        ignoreStart  = 1'b1;
        gapMode      = 2;
        lastStartCyc = -1;
        base         = startCount;
        wr(8'h31);
        wr(8'h32);
        wr(8'h33);
        drain(200);
        chk("stuck_starts", 32'(startCount - base), 3);
        ignoreStart  = 1'b0;
        gapMode      = 1;
        lastStartCyc = -1;

        // Reset while a byte is on the wire with five queued behind it.
        for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i));
        chk("mid_count5", 32'(count), 5);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_start", 32'(tx_start), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        wr(8'h5A);
        for (int k = 0; k < 100 && !tx_start; k++) cycle();
        chk("mid_restart", 32'(tx_start), 1);
        chk("mid_restart_data", 32'(tx_data), 32'h5A);
        cycle();
        chk("mid_pulse_end", 32'(tx_start), 0);
        drain(200);

        // Randomized writes and clears against the queue model.
        for (int k = 0; k < 600; k++) begin
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_data      = 8'($urandom);
            clr_overflow = ($urandom_range(0, 15) == 0);
            cycle();
        end
        wr_en        = 1'b0;
        clr_overflow = 1'b0;
        drain(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
